apb_master_bridge: RTL

- Single-initiator APB master bridging the RISC-V core's simple request/ready bus to up to N_SLAVES APB peripherals (GPIO, FND, etc.).
- Latches one CPU request, runs the APB SETUP→ACCESS sequence, and decodes the address to one PSEL line.
- Muxes PRDATA/PREADY back from the selected slave and returns data plus a one-cycle ready/err pulse.
- Flags unmapped addresses and stalled slaves (timeout) with an error response.

---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_addr_decoder.sv | 30 +++
 rtl/apb_master_bridge.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared types and default constants for the APB master bridge.
//   apb_state_e    : bridge FSM states (IDLE, SETUP, ACCESS)
//   APB_N_SLAVES   : default number of PSEL lines
//   APB_BASE_ADDR  : default peripheral region base (upper 16 bits decoded)
//   APB_TIMEOUT    : default ACCESS-cycle budget before a stalled slave is abandoned
//   APB_SLOT_W     : width of the slot index taken from addr[15:12]
// ---------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int          APB_N_SLAVES  = 4;
    localparam logic [31:0] APB_BASE_ADDR = 32'h1000_0000;
    localparam int          APB_TIMEOUT   = 16;
    localparam int          APB_SLOT_W    = 4;

endpackage

// File: rtl/apb_addr_decoder.sv
// ---------------------------------------------------------------------------
// apb_addr_decoder
// Combinational peripheral-region decoder. The region is identified by the
// upper 16 address bits; each 4 KB page inside it (addr[15:12]) is one slot.
// Only the address bits that take part in the decode are brought in.
//   addr_hi : in  addr[31:12] of the request
//   hit     : out 1 when the address is inside the region and the slot exists
//   slot    : out slot index addr[15:12] (meaningful only when hit=1)
// ---------------------------------------------------------------------------
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int          N_SLAVES  = APB_N_SLAVES,
    parameter logic [31:0] BASE_ADDR = APB_BASE_ADDR
) (
    input  logic [31:12]           addr_hi,
    output logic                   hit,
    output logic [APB_SLOT_W-1:0]  slot
);

    logic region_match;
    logic slot_valid;

    assign slot         = addr_hi[15:12];
    assign region_match = (addr_hi[31:16] == BASE_ADDR[31:16]);
    // One extra bit so that N_SLAVES = 16 still compares correctly.
    assign slot_valid   = ({1'b0, slot} < (APB_SLOT_W + 1)'(N_SLAVES));
    assign hit          = region_match && slot_valid;

endmodule

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
// Single-initiator APB master. Accepts one CPU request in IDLE, runs the
// SETUP -> ACCESS sequence toward the decoded slave and returns a one-cycle
// ready pulse with read data, or ready+err for an unmapped address or a
// slave that never raises PREADY within TIMEOUT ACCESS cycles.
// All outputs come straight from registers.
//   PCLK, PRESET        : clock, asynchronous active-high reset
//   transfer            : in  request strobe (looked at only in IDLE)
//   write/addr/wdata    : in  request direction, byte address, write data
//   rdata/ready/err     : out response (rdata valid with ready, err qualifies)
//   PADDR/PWDATA/PWRITE : out APB address, write data, direction
//   PENABLE/PSEL        : out APB enable, one-hot slave select
//   PRDATA/PREADY       : in  packed per-slave read data and ready
// ---------------------------------------------------------------------------
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int          N_SLAVES  = APB_N_SLAVES,
    parameter logic [31:0] BASE_ADDR = APB_BASE_ADDR,
    parameter int          TIMEOUT   = APB_TIMEOUT
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     transfer,
    input  logic                     write,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     ready,
    output logic                     err,
    output logic [31:0]              PADDR,
    output logic [31:0]              PWDATA,
    output logic                     PWRITE,
    output logic                     PENABLE,
    output logic [N_SLAVES-1:0]      PSEL,
    input  logic [32*N_SLAVES-1:0]   PRDATA,
    input  logic [N_SLAVES-1:0]      PREADY
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e              state_reg, state_next;
    logic [N_SLAVES-1:0]     psel_reg, psel_next;
    logic                    penable_reg, penable_next;
    logic                    pwrite_reg, pwrite_next;
    logic [31:0]             paddr_reg, paddr_next;
    logic [31:0]             pwdata_reg, pwdata_next;
    logic [31:0]             rdata_reg, rdata_next;
    logic                    ready_reg, ready_next;
    logic                    err_reg, err_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;

    logic                    dec_hit;
    logic [APB_SLOT_W-1:0]   dec_slot;
    logic [N_SLAVES-1:0]     dec_onehot;
    logic                    sel_ready;
    logic [31:0]             sel_rdata;
    logic [31:0]             rd_masked [N_SLAVES];

    apb_addr_decoder #(
        .N_SLAVES  (N_SLAVES),
        .BASE_ADDR (BASE_ADDR)
    ) u_decoder (
        .addr_hi (addr[31:12]),
        .hit     (dec_hit),
        .slot    (dec_slot)
    );

    // The latched one-hot PSEL doubles as the stored slot index: it steers
    // the PREADY/PRDATA mux, so unselected slaves can never complete a transfer.
    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slave
            assign dec_onehot[gi] = (dec_slot == APB_SLOT_W'(gi));
            assign rd_masked[gi]  = PRDATA[32*gi +: 32] & {32{psel_reg[gi]}};
        end
    endgenerate

    assign sel_ready = |(psel_reg & PREADY);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            sel_rdata = sel_rdata | rd_masked[i];
        end
    end

    always_comb begin
        state_next   = state_reg;
        psel_next    = psel_reg;
        penable_next = penable_reg;
        pwrite_next  = pwrite_reg;
        paddr_next   = paddr_reg;
        pwdata_next  = pwdata_reg;
        rdata_next   = rdata_reg;
        ready_next   = 1'b0;
        err_next     = 1'b0;
        cnt_next     = cnt_reg;

        unique case (state_reg)
            IDLE: begin
                if (transfer) begin
                    if (dec_hit) begin
                        paddr_next   = addr;
                        pwdata_next  = wdata;
                        pwrite_next  = write;
                        psel_next    = dec_onehot;
                        penable_next = 1'b0;
                        state_next   = SETUP;
                    end else begin
                        // Unmapped: answer immediately, bus stays untouched.
                        ready_next = 1'b1;
                        err_next   = 1'b1;
                        rdata_next = '0;
                    end
                end
            end

            SETUP: begin
                penable_next = 1'b1;
                cnt_next     = '0;
                state_next   = ACCESS;
            end

            ACCESS: begin
                if (sel_ready) begin
                    state_next   = IDLE;
                    psel_next    = '0;
                    penable_next = 1'b0;
                    ready_next   = 1'b1;
                    rdata_next   = pwrite_reg ? 32'd0 : sel_rdata;
                end else if (cnt_reg == CNT_LAST) begin
                    // Slave stalled for TIMEOUT ACCESS cycles: abandon it.
                    state_next   = IDLE;
                    psel_next    = '0;
                    penable_next = 1'b0;
                    ready_next   = 1'b1;
                    err_next     = 1'b1;
                    rdata_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next   = IDLE;
                psel_next    = '0;
                penable_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg   <= IDLE;
            psel_reg    <= '0;
            penable_reg <= 1'b0;
            pwrite_reg  <= 1'b0;
            paddr_reg   <= '0;
            pwdata_reg  <= '0;
            rdata_reg   <= '0;
            ready_reg   <= 1'b0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            psel_reg    <= psel_next;
            penable_reg <= penable_next;
            pwrite_reg  <= pwrite_next;
            paddr_reg   <= paddr_next;
            pwdata_reg  <= pwdata_next;
            rdata_reg   <= rdata_next;
            ready_reg   <= ready_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign PSEL    = psel_reg;
    assign PENABLE = penable_reg;
    assign PWRITE  = pwrite_reg;
    assign PADDR   = paddr_reg;
    assign PWDATA  = pwdata_reg;
    assign rdata   = rdata_reg;
    assign ready   = ready_reg;
    assign err     = err_reg;

endmodule
